// File: rtl/viterbi_controller.sv
// Viterbi POS-tagging sequencer.
// Moore FSM driving datapath enables, selects and write strobes.
module viterbi_controller #(
  parameter int size_state = 4,
  parameter int size_key   = 4,
  parameter int num_pos    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  error,
  input  logic [size_state-1:0] i,
  input  logic                  multiple_source,
  input  logic                  endline,
  input  logic [size_key-1:0]   key,
  input  logic                  stack_empty,
  output logic [size_state-1:0] state,
  output logic                  increment_enable_Words_control,
  output logic                  increment_enable_Transition_control,
  output logic                  increment_enable_Emission_control,
  output logic                  S_key_1,
  output logic                  S_key_0,
  output logic                  RW_Key_reg,
  output logic                  decrement_enable,
  output logic                  S_POS_HMM_2,
  output logic                  S_POS_HMM_1,
  output logic                  S_POS_HMM_0,
  output logic                  S_posibility_1,
  output logic                  S_posibility_0,
  output logic                  RW_HMM_matrix,
  output logic                  change_enable,
  output logic                  choose_output,
  output logic                  RW_Pre_addr_encode,
  output logic                  RW_Pre_Posibility,
  output logic                  RW_Max_posibility,
  output logic                  RW_Stack_POS,
  output logic                  reset_Stack_POS
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    FETCH = 4'd1,
    CHECK = 4'd2,
    INIT  = 4'd3,
    TRANS = 4'd4,
    CMP   = 4'd5,
    TIE   = 4'd6,
    EMIT  = 4'd7,
    NEXTW = 4'd8,
    BSEL  = 4'd9,
    POP   = 4'd10,
    DONE  = 4'd11,
    ERR   = 4'd12
  } st_t;

  localparam logic [size_state-1:0] LAST =
    size_state'(num_pos - 1);

  st_t st_q, st_d;
  logic last_pos;

  assign last_pos = (i == LAST);
  assign state    = size_state'(st_q);

  // State register, cleared asynchronously to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st_q <= IDLE;
    else        st_q <= st_d;
  end

  // Next-state: error aborts any active state.
  always_comb begin
    st_d = IDLE;
    unique case (st_q)
      IDLE:  st_d = start ? FETCH : IDLE;
      FETCH: st_d = endline ? BSEL : CHECK;
      CHECK: st_d = (key == '0) ? INIT : TRANS;
      INIT:  st_d = last_pos ? NEXTW : INIT;
      TRANS: st_d = CMP;
      CMP: begin
        if (multiple_source) st_d = TIE;
        else if (last_pos)   st_d = EMIT;
        else                 st_d = TRANS;
      end
      TIE:   st_d = last_pos ? EMIT : TRANS;
      EMIT:  st_d = NEXTW;
      NEXTW: st_d = FETCH;
      BSEL:  st_d = POP;
      POP:   st_d = stack_empty ? DONE : POP;
      DONE:  st_d = start ? DONE : IDLE;
      ERR:   st_d = start ? ERR : IDLE;
      default: st_d = IDLE;
    endcase
    if (error && st_q inside {[FETCH:POP]}) st_d = ERR;
  end

  // Moore output decode; unknown codes look like IDLE.
  always_comb begin
    increment_enable_Words_control      = 1'b0;
    increment_enable_Transition_control = 1'b0;
    increment_enable_Emission_control   = 1'b0;
    S_key_1            = 1'b0;
    S_key_0            = 1'b0;
    RW_Key_reg         = 1'b0;
    decrement_enable   = 1'b0;
    S_POS_HMM_2        = 1'b0;
    S_POS_HMM_1        = 1'b0;
    S_POS_HMM_0        = 1'b0;
    S_posibility_1     = 1'b0;
    S_posibility_0     = 1'b0;
    RW_HMM_matrix      = 1'b0;
    change_enable      = 1'b0;
    choose_output      = 1'b0;
    RW_Pre_addr_encode = 1'b0;
    RW_Pre_Posibility  = 1'b0;
    RW_Max_posibility  = 1'b0;
    RW_Stack_POS       = 1'b0;
    reset_Stack_POS    = 1'b0;
    unique case (st_q)
      FETCH: begin
        increment_enable_Words_control = 1'b1;
        RW_Key_reg = 1'b1;
      end
      CHECK: S_key_0 = 1'b1;
      INIT: begin
        S_POS_HMM_0 = 1'b1;
        increment_enable_Emission_control = 1'b1;
        RW_Pre_Posibility = 1'b1;
      end
      TRANS: begin
        S_POS_HMM_1    = 1'b1;
        S_posibility_0 = 1'b1;
        increment_enable_Transition_control = 1'b1;
      end
      CMP: begin
        S_posibility_1     = 1'b1;
        RW_Max_posibility  = 1'b1;
        RW_Pre_addr_encode = 1'b1;
      end
      TIE: change_enable = 1'b1;
      EMIT: begin
        S_POS_HMM_2       = 1'b1;
        S_posibility_1    = 1'b1;
        S_posibility_0    = 1'b1;
        increment_enable_Emission_control = 1'b1;
        RW_Pre_Posibility = 1'b1;
        RW_HMM_matrix     = 1'b1;
        RW_Stack_POS      = 1'b1;
      end
      NEXTW: begin
        S_key_1    = 1'b1;
        RW_Key_reg = 1'b1;
      end
      BSEL: choose_output = 1'b1;
      POP: begin
        choose_output    = 1'b1;
        decrement_enable = 1'b1;
      end
      DONE: ;
      default: reset_Stack_POS = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_viterbi_controller.sv
// Directed bench for viterbi_controller.
// Checks state and the full output vector each step.
module tb_viterbi_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       error;
  logic [3:0] i;
  logic       multiple_source;
  logic       endline;
  logic [3:0] key;
  logic       stack_empty;
  logic [3:0] state;
  logic inc_w, inc_t, inc_e, sk1, sk0, rw_key, dec;
  logic h2, h1, h0, p1, p0, rw_hmm, chg, chs;
  logic rw_pa, rw_pp, rw_max, rw_stk, rst_stk;
  logic [19:0] outs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  viterbi_controller dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .error(error),
    .i(i),
    .multiple_source(multiple_source),
    .endline(endline),
    .key(key),
    .stack_empty(stack_empty),
    .state(state),
    .increment_enable_Words_control(inc_w),
    .increment_enable_Transition_control(inc_t),
    .increment_enable_Emission_control(inc_e),
    .S_key_1(sk1),
    .S_key_0(sk0),
    .RW_Key_reg(rw_key),
    .decrement_enable(dec),
    .S_POS_HMM_2(h2),
    .S_POS_HMM_1(h1),
    .S_POS_HMM_0(h0),
    .S_posibility_1(p1),
    .S_posibility_0(p0),
    .RW_HMM_matrix(rw_hmm),
    .change_enable(chg),
    .choose_output(chs),
    .RW_Pre_addr_encode(rw_pa),
    .RW_Pre_Posibility(rw_pp),
    .RW_Max_posibility(rw_max),
    .RW_Stack_POS(rw_stk),
    .reset_Stack_POS(rst_stk)
  );

  assign outs = {inc_w, inc_t, inc_e, sk1, sk0,
                 rw_key, dec, h2, h1, h0, p1, p0,
                 rw_hmm, chg, chs, rw_pa, rw_pp,
                 rw_max, rw_stk, rst_stk};

  // Expected output vector per state, from the output table.
  function automatic logic [19:0] exp_outs(int s);
    logic [19:0] e;
    e = '0;
    case (s)
      1: begin e[19] = 1; e[14] = 1; end
      2: e[15] = 1;
      3: begin e[10] = 1; e[17] = 1; e[3] = 1; end
      4: begin e[11] = 1; e[8] = 1; e[18] = 1; end
      5: begin e[9] = 1; e[2] = 1; e[4] = 1; end
      6: e[6] = 1;
      7: begin
        e[12] = 1; e[9] = 1; e[8] = 1; e[17] = 1;
        e[3] = 1; e[7] = 1; e[1] = 1;
      end
      8: begin e[16] = 1; e[14] = 1; end
      9: e[5] = 1;
      10: begin e[5] = 1; e[13] = 1; end
      11: e = '0;
      default: e[0] = 1;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input int s);
    total++;
    assert (state === 4'(s)) else begin
      bad++;
      $error("FAIL %s state: got %0d want %0d",
             tag, state, s);
    end
    total++;
    assert (outs === exp_outs(s)) else begin
      bad++;
      $error("FAIL %s outs: got %05h want %05h",
             tag, outs, exp_outs(s));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    error = 1'b0;
    i = 4'd0;
    multiple_source = 1'b0;
    endline = 1'b0;
    key = 4'd0;
    stack_empty = 1'b0;
    #3;
    chk("reset", 0);
    step();
    reset = 1'b1;
    step(); chk("idle_hold0", 0);
    step(); chk("idle_hold1", 0);

    // first word: INIT loop over all tags
    start = 1'b1;
    step(); chk("w0_fetch", 1);
    step(); chk("w0_check", 2);
    step(); chk("w0_init_i0", 3);
    for (int k = 1; k < 7; k++) begin
      i = 4'(k);
      step(); chk("w0_init_loop", 3);
    end
    i = 4'd7;
    step(); chk("w0_nextw", 8);
    step(); chk("w0_refetch", 1);

    // later word, no ties
    key = 4'd3;
    i = 4'd0;
    step(); chk("w3_check", 2);
    step(); chk("w3_trans", 4);
    step(); chk("w3_cmp", 5);
    step(); chk("w3_trans2", 4);
    i = 4'd7;
    step(); chk("w3_cmp2", 5);
    step(); chk("w3_emit", 7);
    step(); chk("w3_nextw", 8);
    step(); chk("w3_fetch", 1);

    // ties: mid-range and last index
    i = 4'd2;
    step(); chk("t_check", 2);
    step(); chk("t_trans", 4);
    step(); chk("t_cmp", 5);
    multiple_source = 1'b1;
    step(); chk("t_tie_i2", 6);
    multiple_source = 1'b0;
    step(); chk("t_tie_to_trans", 4);
    step(); chk("t_cmp2", 5);
    i = 4'd7;
    multiple_source = 1'b1;
    step(); chk("t_tie_i7", 6);
    multiple_source = 1'b0;
    step(); chk("t_tie_to_emit", 7);
    step(); chk("t_nextw", 8);
    step(); chk("t_fetch", 1);

    // end of sentence: backtrack
    endline = 1'b1;
    stack_empty = 1'b0;
    step(); chk("b_bsel", 9);
    step(); chk("b_pop0", 10);
    step(); chk("b_pop1", 10);
    stack_empty = 1'b1;
    step(); chk("b_done", 11);
    step(); chk("b_done_hold", 11);
    error = 1'b1;
    step(); chk("b_done_err_ignored", 11);
    error = 1'b0;
    start = 1'b0;
    step(); chk("b_idle", 0);

    // error abort from TRANS
    endline = 1'b0;
    stack_empty = 1'b0;
    key = 4'd3;
    i = 4'd0;
    start = 1'b1;
    step(); chk("e_fetch", 1);
    step(); chk("e_check", 2);
    step(); chk("e_trans", 4);
    error = 1'b1;
    step(); chk("e_err", 12);
    step(); chk("e_err_hold", 12);
    start = 1'b0;
    step(); chk("e_idle", 0);
    step(); chk("e_idle_err_ignored", 0);
    error = 1'b0;

    // async reset mid-POP
    start = 1'b1;
    endline = 1'b1;
    step(); chk("r_fetch", 1);
    step(); chk("r_bsel", 9);
    step(); chk("r_pop", 10);
    #2;
    reset = 1'b0;
    #1;
    chk("r_async_reset", 0);
    step();
    reset = 1'b1;
    start = 1'b0;
    step(); chk("r_after", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
